// File: rtl/arm_pkg.sv
// Shared constants, types and helpers for the ARM execute stage.
package arm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 4;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned SHOP_W = 12;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned SR_W   = 4;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [CMD_W-1:0] EXE_MOV = 4'd1;
    localparam logic [CMD_W-1:0] EXE_ADD = 4'd2;
    localparam logic [CMD_W-1:0] EXE_ADC = 4'd3;
    localparam logic [CMD_W-1:0] EXE_SUB = 4'd4;
    localparam logic [CMD_W-1:0] EXE_SBC = 4'd5;
    localparam logic [CMD_W-1:0] EXE_AND = 4'd6;
    localparam logic [CMD_W-1:0] EXE_ORR = 4'd7;
    localparam logic [CMD_W-1:0] EXE_EOR = 4'd8;
    localparam logic [CMD_W-1:0] EXE_MVN = 4'd9;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b01;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b10;

    localparam int unsigned SR_N = 3;
    localparam int unsigned SR_Z = 2;
    localparam int unsigned SR_C = 1;
    localparam int unsigned SR_V = 0;

    // EXE/MEM boundary payload
    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        word_t             alu_result;
        word_t             store_value;
        logic [REG_AW-1:0] wb_reg_dest;
    } exe_mem_t;

    // Rotate right; a zero amount returns x unchanged because x << 32 is zero.
    function automatic word_t ror32(input word_t x, input logic [4:0] amt);
        return (x >> amt) | (x << (6'd32 - {1'b0, amt}));
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage.
interface exe_stage_if;

    logic                           freeze;
    logic                           wb_en_in;
    logic                           mem_r_en_in;
    logic                           mem_w_en_in;
    logic                           branch_taken_in;
    logic                           do_update_sr_in;
    logic [arm_pkg::CMD_W-1:0]      execute_command_in;
    logic [arm_pkg::REG_AW-1:0]     wb_reg_dest_in;
    arm_pkg::word_t                 pc_plus_four_in;
    arm_pkg::word_t                 branch_immediate_in;
    logic [arm_pkg::SHOP_W-1:0]     instr_shifter_opperand_in;
    logic                           instr_is_immediate_in;
    arm_pkg::word_t                 val_rn_in;
    arm_pkg::word_t                 val_rm_in;
    logic [arm_pkg::SR_W-1:0]       status_bits_in;
    logic [arm_pkg::FWD_W-1:0]      fwd_sel_src1;
    logic [arm_pkg::FWD_W-1:0]      fwd_sel_src2;
    arm_pkg::word_t                 mem_fwd_value;
    arm_pkg::word_t                 wb_fwd_value;

    logic                           branch_taken_out;
    arm_pkg::word_t                 branch_address;
    logic [arm_pkg::SR_W-1:0]       status_reg_out;
    logic                           wb_en_out;
    logic                           mem_r_en_out;
    logic                           mem_w_en_out;
    arm_pkg::word_t                 alu_result_out;
    arm_pkg::word_t                 store_value_out;
    logic [arm_pkg::REG_AW-1:0]     wb_reg_dest_out;

    modport master (
        output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, branch_taken_in, do_update_sr_in,
               execute_command_in, wb_reg_dest_in, pc_plus_four_in, branch_immediate_in,
               instr_shifter_opperand_in, instr_is_immediate_in, val_rn_in, val_rm_in,
               status_bits_in, fwd_sel_src1, fwd_sel_src2, mem_fwd_value, wb_fwd_value,
        input  branch_taken_out, branch_address, status_reg_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, alu_result_out, store_value_out, wb_reg_dest_out
    );

    modport slave (
        input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, branch_taken_in, do_update_sr_in,
               execute_command_in, wb_reg_dest_in, pc_plus_four_in, branch_immediate_in,
               instr_shifter_opperand_in, instr_is_immediate_in, val_rn_in, val_rm_in,
               status_bits_in, fwd_sel_src1, fwd_sel_src2, mem_fwd_value, wb_fwd_value,
        output branch_taken_out, branch_address, status_reg_out, wb_en_out, mem_r_en_out,
               mem_w_en_out, alu_result_out, store_value_out, wb_reg_dest_out
    );

endinterface

// File: rtl/exe_stage_val2_generator.sv
// Second ALU operand from the shifter-operand field: rotated immediate, memory offset or shifted Rm.
module val2_generator
    import arm_pkg::*;
(
    input  logic [SHOP_W-1:0] shifter_operand,
    input  logic              is_immediate,
    input  logic              mem_access,
    input  word_t             m,
    output word_t             val2_c
);

    logic [4:0] imm5;
    logic [1:0] shift_type;
    logic [4:0] imm_rot;

    assign imm5       = shifter_operand[11:7];
    assign shift_type = shifter_operand[6:5];
    assign imm_rot    = {shifter_operand[11:8], 1'b0};

    always_comb begin
        val2_c = m;
        if (is_immediate) begin
            val2_c = ror32(DATA_W'(shifter_operand[7:0]), imm_rot);
        end else if (mem_access) begin
            val2_c = DATA_W'(shifter_operand);
        end else begin
            unique case (shift_type)
                SHIFT_LSL: val2_c = m << imm5;
                SHIFT_LSR: val2_c = m >> imm5;
                SHIFT_ASR: val2_c = word_t'($signed(m) >>> imm5);
                SHIFT_ROR: val2_c = ror32(m, imm5);
                default:   val2_c = m;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: operand forwarding, ALU, NZCV register, branch target and EXE/MEM register.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module exe_stage
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    exe_stage_if.slave        bus
);

    localparam int unsigned SUM_W = DATA_W + 1;

    word_t             a;
    word_t             m;
    word_t             val2;
    word_t             res;
    logic [SUM_W-1:0]  sum;
    logic              arith;
    logic              is_sub;
    logic              c_in;
    logic [SR_W-1:0]   flags;

    exe_mem_t          exe_mem_d, exe_mem_q;
    logic [SR_W-1:0]   status_d, status_q;

`ifdef FORWARDING_EN
    // Operand steering from the later pipeline stages
    always_comb begin
        case (bus.fwd_sel_src1)
            FWD_MEM: a = bus.mem_fwd_value;
            FWD_WB:  a = bus.wb_fwd_value;
            default: a = bus.val_rn_in;
        endcase
        case (bus.fwd_sel_src2)
            FWD_MEM: m = bus.mem_fwd_value;
            FWD_WB:  m = bus.wb_fwd_value;
            default: m = bus.val_rm_in;
        endcase
    end
`else
    assign a = bus.val_rn_in;
    assign m = bus.val_rm_in;

    logic unused_fwd;
    assign unused_fwd = ^{bus.fwd_sel_src1, bus.fwd_sel_src2, bus.mem_fwd_value, bus.wb_fwd_value};
`endif

    logic unused_status;
    assign unused_status = ^{bus.status_bits_in[SR_N], bus.status_bits_in[SR_Z],
                             bus.status_bits_in[SR_V]};

    val2_generator u_val2 (
        .shifter_operand (bus.instr_shifter_opperand_in),
        .is_immediate    (bus.instr_is_immediate_in),
        .mem_access      (bus.mem_r_en_in | bus.mem_w_en_in),
        .m               (m),
        .val2_c          (val2)
    );

    // ALU; subtraction is a + ~b + 1 so the carry-out is the not-borrow flag
    always_comb begin
        sum    = '0;
        res    = '0;
        arith  = 1'b0;
        is_sub = 1'b0;
        c_in   = bus.status_bits_in[SR_C];
        case (bus.execute_command_in)
            EXE_MOV: res = val2;
            EXE_MVN: res = ~val2;
            EXE_ADD: begin sum = {1'b0, a} + {1'b0, val2};              arith = 1'b1; end
            EXE_ADC: begin sum = {1'b0, a} + {1'b0, val2} + SUM_W'(c_in); arith = 1'b1; end
            EXE_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~val2} + SUM_W'(1);
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            EXE_SBC: begin
                sum    = {1'b0, a} + {1'b0, ~val2} + SUM_W'(c_in);
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            EXE_AND: res = a & val2;
            EXE_ORR: res = a | val2;
            EXE_EOR: res = a ^ val2;
            default: res = '0;
        endcase
        if (arith) res = sum[DATA_W-1:0];

        flags       = status_q;
        flags[SR_N] = res[DATA_W-1];
        flags[SR_Z] = (res == '0);
        if (arith) begin
            flags[SR_C] = sum[DATA_W];
            flags[SR_V] = is_sub ? ((a[DATA_W-1] != val2[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]))
                                 : ((a[DATA_W-1] == val2[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]));
        end
    end

    // Next state of the EXE/MEM register and SR; freeze holds both
    always_comb begin
        exe_mem_d = exe_mem_q;
        status_d  = status_q;
        if (!bus.freeze) begin
            exe_mem_d.wb_en       = bus.wb_en_in;
            exe_mem_d.mem_r_en    = bus.mem_r_en_in;
            exe_mem_d.mem_w_en    = bus.mem_w_en_in;
            exe_mem_d.alu_result  = res;
            exe_mem_d.store_value = m;
            exe_mem_d.wb_reg_dest = bus.wb_reg_dest_in;
            if (bus.do_update_sr_in) status_d = flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_mem_q <= '0;
            status_q  <= '0;
        end else begin
            exe_mem_q <= exe_mem_d;
            status_q  <= status_d;
        end
    end

    assign bus.branch_taken_out = bus.branch_taken_in;
    assign bus.branch_address   = bus.pc_plus_four_in + (bus.branch_immediate_in << 2);
    assign bus.status_reg_out   = status_q;
    assign bus.wb_en_out        = exe_mem_q.wb_en;
    assign bus.mem_r_en_out     = exe_mem_q.mem_r_en;
    assign bus.mem_w_en_out     = exe_mem_q.mem_w_en;
    assign bus.alu_result_out   = exe_mem_q.alu_result;
    assign bus.store_value_out  = exe_mem_q.store_value;
    assign bus.wb_reg_dest_out  = exe_mem_q.wb_reg_dest;

endmodule
